// File: rtl/dds_pkg.sv
// Shared definitions for the AD9833 loader: sequencer states, register
// window offsets, command word constants and the configuration record.
package dds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_W3   = 3'd4,
    ST_W4   = 3'd5
  } dds_state_e;

  localparam logic [2:0] OFS_FREQ0  = 3'd0;
  localparam logic [2:0] OFS_FREQ1  = 3'd1;
  localparam logic [2:0] OFS_FREQ2  = 3'd2;
  localparam logic [2:0] OFS_FREQ3  = 3'd3;
  localparam logic [2:0] OFS_PHASE0 = 3'd4;
  localparam logic [2:0] OFS_PHASE1 = 3'd5;
  localparam logic [2:0] OFS_CTRL   = 3'd6;
  localparam logic [2:0] OFS_GO     = 3'd7;

  localparam logic [15:0] WORD_CTRL_RESET = 16'h2100;
  localparam logic [15:0] WORD_CTRL_RUN   = 16'h2000;
  localparam logic [15:0] WORD_FREQ0_SEL  = 16'h4000;
  localparam logic [15:0] WORD_FREQ1_SEL  = 16'h8000;
  localparam logic [15:0] WORD_PHASE_SEL  = 16'hC000;

  typedef struct packed {
    logic [27:0] freq;
    logic [11:0] phase;
    logic        psel;
    logic        fsel;
  } dds_cfg_t;

endpackage

// File: rtl/dds_regs.sv
// Port decode and register file for the 8-address DDS window; GO is a
// combinational pulse so the sequencer can start on the following cycle.
module dds_regs
  import dds_pkg::*;
#(
  parameter logic [7:0] BASE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_port_id,
  input  logic [7:0] i_out_port,
  input  logic       i_write_strobe,
  output dds_cfg_t   o_cfg,
  output logic       o_go
);

  logic [7:0] w_rel;
  logic [2:0] w_offset;
  logic       w_hit;
  dds_cfg_t   r_cfg;

  // Ports below BASE wrap to large values and fall outside the window.
  assign w_rel    = i_port_id - BASE;
  assign w_offset = w_rel[2:0];
  assign w_hit    = i_write_strobe && (w_rel < 8'd8);
  assign o_go     = w_hit && (w_offset == OFS_GO);
  assign o_cfg    = r_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg <= '0;
    end else if (w_hit) begin
      case (w_offset)
        OFS_FREQ0:  r_cfg.freq[7:0]   <= i_out_port;
        OFS_FREQ1:  r_cfg.freq[15:8]  <= i_out_port;
        OFS_FREQ2:  r_cfg.freq[23:16] <= i_out_port;
        OFS_FREQ3:  r_cfg.freq[27:24] <= i_out_port[3:0];
        OFS_PHASE0: r_cfg.phase[7:0]  <= i_out_port;
        OFS_PHASE1: r_cfg.phase[11:8] <= i_out_port[3:0];
        OFS_CTRL:   {r_cfg.psel, r_cfg.fsel} <= i_out_port[1:0];
        default:    r_cfg <= r_cfg;
      endcase
    end else begin
      r_cfg <= r_cfg;
    end
  end

endmodule

// File: rtl/dds_loader.sv
// Sequences five AD9833 command words to a ready/valid serializer from a
// snapshot of the register file taken when each sequence starts.
module dds_loader
  import dds_pkg::*;
#(
  parameter logic [7:0] BASE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  port_id,
  input  logic [7:0]  out_port,
  input  logic        write_strobe,
  output logic [15:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy
);

  dds_cfg_t   w_cfg;
  logic       w_go;
  dds_state_e r_state;
  dds_state_e w_state_next;
  dds_cfg_t   r_shadow;
  logic       r_pending;
  logic       w_xfer;
  logic       w_restart;
  logic       w_start;
  logic [15:0] w_freq_sel;

  dds_regs #(.BASE(BASE)) u_regs (
    .clk           (clk),
    .rst           (rst),
    .i_port_id     (port_id),
    .i_out_port    (out_port),
    .i_write_strobe(write_strobe),
    .o_cfg         (w_cfg),
    .o_go          (w_go)
  );

  assign word_valid = (r_state != ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign w_xfer     = word_valid && word_ready;
  // A GO coinciding with the last transfer restarts just like a pending one.
  assign w_restart  = (r_state == ST_W4) && w_xfer && (r_pending || w_go);
  assign w_start    = ((r_state == ST_IDLE) && w_go) || w_restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_shadow <= w_cfg;
      end else begin
        r_shadow <= r_shadow;
      end
      if (w_restart) begin
        r_pending <= 1'b0;
      end else if (w_go && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go)   w_state_next = ST_W0; else w_state_next = ST_IDLE;
      ST_W0:   if (w_xfer) w_state_next = ST_W1; else w_state_next = ST_W0;
      ST_W1:   if (w_xfer) w_state_next = ST_W2; else w_state_next = ST_W1;
      ST_W2:   if (w_xfer) w_state_next = ST_W3; else w_state_next = ST_W2;
      ST_W3:   if (w_xfer) w_state_next = ST_W4; else w_state_next = ST_W3;
      ST_W4: begin
        if (w_restart)   w_state_next = ST_W0;
        else if (w_xfer) w_state_next = ST_IDLE;
        else             w_state_next = ST_W4;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_freq_sel = r_shadow.fsel ? WORD_FREQ1_SEL : WORD_FREQ0_SEL;

  always_comb begin
    word_data = 16'h0000;
    case (r_state)
      ST_W0:   word_data = WORD_CTRL_RESET | {4'd0, r_shadow.fsel, r_shadow.psel, 10'd0};
      ST_W1:   word_data = w_freq_sel | {2'b00, r_shadow.freq[13:0]};
      ST_W2:   word_data = w_freq_sel | {2'b00, r_shadow.freq[27:14]};
      ST_W3:   word_data = WORD_PHASE_SEL | {2'b00, r_shadow.psel, 1'b0, r_shadow.phase};
      ST_W4:   word_data = WORD_CTRL_RUN | {4'd0, r_shadow.fsel, r_shadow.psel, 10'd0};
      default: word_data = 16'h0000;
    endcase
  end

endmodule
